ethernet_sys_debug_cmd_sysclk: RTL



---
 rtl/debug_slave_pkg.sv | 17 +
 rtl/debug_strobe_sync.sv | 35 +++
 rtl/ethernet_sys_debug_cmd_sysclk.sv | 127 ++++++++++++
 3 files changed

// File: rtl/debug_slave_pkg.sv
// Shared helpers for the CPU JTAG debug slave: channel width and the
// action/channel field positions inside the shift-register word.
package debug_slave_pkg;

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int unsigned action_pos(input int unsigned data_width);
    return data_width - 1;
  endfunction

  function automatic int unsigned ch_msb(input int unsigned data_width);
    return data_width - 2;
  endfunction

endpackage

// File: rtl/debug_strobe_sync.sv
// Synchronises one tck-domain level strobe into clk and emits a one-cycle
// rising-edge pulse once the strobe has been seen low after reset.
module debug_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   armed;

  // fill marks when the chain holds real samples, so the reset zeros in the
  // chain cannot arm a strobe that is held high across reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], strobe};
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev  <= chain[SYNC_STAGES-1];
      armed <= armed | (fill[SYNC_STAGES-1] & ~chain[SYNC_STAGES-1]);
    end
  end

  assign rise = armed & chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ethernet_sys_debug_cmd_sysclk.sv
// System-clock half of the JTAG debug slave: captures IR/DR updates into a
// show-ahead command FIFO and issues per-channel action pulses on pop.
module ethernet_sys_debug_cmd_sysclk
  import debug_slave_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DATA_WIDTH  = 38,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [DATA_WIDTH-1:0]           sr,
  input  logic                            vs_uir,
  input  logic                            vs_udr,
  output logic [IR_WIDTH-1:0]             cur_ir,
  output logic                            ir_update,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [IR_WIDTH-1:0]             cmd_ir,
  output logic [DATA_WIDTH-1:0]           jdo,
  output logic [NUM_CH-1:0]               take_action,
  output logic [NUM_CH-1:0]               take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            bad_ch,
  input  logic                            err_clr
);

  localparam int unsigned CH_W    = ch_w(NUM_CH);
  localparam int unsigned ACT_POS = action_pos(DATA_WIDTH);
  localparam int unsigned CH_MSB  = ch_msb(DATA_WIDTH);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;

  typedef struct packed {
    logic [IR_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0] data;
  } cmd_entry_t;

  cmd_entry_t       mem [FIFO_DEPTH];
  cmd_entry_t       head;
  cmd_entry_t       last_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic             uir_rise;
  logic             udr_rise;
  logic [CH_W-1:0]  cap_ch;
  logic [CH_W-1:0]  head_ch;
  logic             ch_ok;
  logic             full;
  logic             pop;
  logic             push;

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_uir),
    .rise   (uir_rise)
  );

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_udr),
    .rise   (udr_rise)
  );

  assign cap_ch    = sr[CH_MSB -: CH_W];
  assign ch_ok     = 32'(cap_ch) < NUM_CH;
  assign full      = level == LVL_W'(FIFO_DEPTH);
  assign cmd_valid = level != '0;
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_rise & ch_ok & (~full | pop);
  assign head      = mem[rd_ptr];
  assign head_ch   = head.data[CH_MSB -: CH_W];

  // Head is shown while valid; otherwise the last popped entry is held
  assign cmd_ir     = cmd_valid ? head.ir   : last_q.ir;
  assign jdo        = cmd_valid ? head.data : last_q.data;
  assign fifo_level = level;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (head.data[ACT_POS]) take_action[head_ch]    = 1'b1;
      else                    take_no_action[head_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ir: ir_in, data: sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      last_q    <= '0;
      overflow  <= 1'b0;
      bad_ch    <= 1'b0;
      cur_ir    <= '0;
      ir_update <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  last_q <= head;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (udr_rise & ch_ok & full & ~pop) overflow <= 1'b1;
      else if (err_clr)                   overflow <= 1'b0;
      if (udr_rise & ~ch_ok)              bad_ch <= 1'b1;
      else if (err_clr)                   bad_ch <= 1'b0;
      ir_update <= uir_rise;
      if (uir_rise) cur_ir <= ir_in;
    end
  end

endmodule
